// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcode/funct encodings, ALU operation enum, link
//                register index and immediate sign-extension helper for the
//                single-cycle MIPS-subset core.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    // Link register written by jal
    localparam logic [4:0] c_RA = 5'd31;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Big-endian byte-addressed data store. Word read is
//                combinational, word write happens on the rising edge.
//                Not affected by reset so preloaded contents survive.
//  Revision    : 1.0 - initial release
//  Ports       : clk     - clock
//                i_we    - word write enable
//                i_addr  - byte address (word aligned) for read and write
//                i_wdata - write data
//                o_rdata - word at i_addr
// ============================================================================
module data_memory #(
    parameter int BYTES = 256     // power of two so addresses wrap naturally
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(BYTES)-1:0] i_addr,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);
    localparam int c_AW = $clog2(BYTES);

    logic [7:0] memory [0:BYTES-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            memory[i_addr]            <= i_wdata[31:24];
            memory[i_addr + c_AW'(1)] <= i_wdata[23:16];
            memory[i_addr + c_AW'(2)] <= i_wdata[15:8];
            memory[i_addr + c_AW'(3)] <= i_wdata[7:0];
        end
    end

    assign o_rdata = {memory[i_addr],
                      memory[i_addr + c_AW'(1)],
                      memory[i_addr + c_AW'(2)],
                      memory[i_addr + c_AW'(3)]};

endmodule : data_memory
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_memory
//  Description : Big-endian byte-addressed instruction store with a
//                combinational word read. Contents are loaded from outside
//                through the byte array `memory`; the synchronous word write
//                port exists for loaders and is tied off inside the core.
//  Revision    : 1.0 - initial release
//  Ports       : clk      - clock for the write port
//                i_we     - word write enable
//                i_waddr  - write byte address (word aligned)
//                i_wdata  - write data
//                i_addr   - read byte address (word aligned)
//                o_instr  - instruction word at i_addr
// ============================================================================
module instruction_memory #(
    parameter int BYTES = 256     // power of two so addresses wrap naturally
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(BYTES)-1:0] i_waddr,
    input  logic [31:0]              i_wdata,
    input  logic [$clog2(BYTES)-1:0] i_addr,
    output logic [31:0]              o_instr
);
    localparam int c_AW = $clog2(BYTES);

    logic [7:0] memory [0:BYTES-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            memory[i_waddr]           <= i_wdata[31:24];
            memory[i_waddr + c_AW'(1)] <= i_wdata[23:16];
            memory[i_waddr + c_AW'(2)] <= i_wdata[15:8];
            memory[i_waddr + c_AW'(3)] <= i_wdata[7:0];
        end
    end

    assign o_instr = {memory[i_addr],
                      memory[i_addr + c_AW'(1)],
                      memory[i_addr + c_AW'(2)],
                      memory[i_addr + c_AW'(3)]};

endmodule : instruction_memory
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 32 x 32-bit register file, two combinational read ports and
//                one synchronous write port. Register 0 always reads zero and
//                ignores writes. Synchronous reset clears every register.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_we/i_waddr/i_wdata - write port
//                i_raddr1/o_rdata1    - read port 1
//                i_raddr2/o_rdata2    - read port 2
// ============================================================================
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);
    logic [31:0] r_regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];

endmodule : reg_file
`default_nettype wire

// File: rtl/mips_processor.sv
`default_nettype none
// ============================================================================
//  Module      : mips_processor
//  Description : Single-cycle 32-bit MIPS-subset core. Every rising edge
//                fetches, decodes and retires one instruction. Decode and ALU
//                live here; instruction memory, data memory and register file
//                are sub-modules. Branch targets are absolute (sext(imm)<<2).
//  Revision    : 1.0 - initial release
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset (pc and registers to 0,
//                        memories untouched)
// ============================================================================
module mips_processor
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 256,
    parameter int DMEM_BYTES = 256
) (
    input  logic clk,
    input  logic reset
);
    localparam int c_IAW = $clog2(IMEM_BYTES);
    localparam int c_DAW = $clog2(DMEM_BYTES);

    logic [31:0] pc;

    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;

    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic [31:0] w_imm_sext;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    alu_op_t     w_alu_op;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;

    logic        w_reg_we;
    logic [4:0]  w_wr_idx;
    logic [31:0] w_wr_data;
    logic        w_mem_we;
    logic        w_mem_to_reg;
    logic        w_link;
    logic [31:0] w_next_pc;
    logic [31:0] w_mem_rdata;

    // ------------------------------------------------------------------
    // Fetch
    // ------------------------------------------------------------------
    instruction_memory #(
        .BYTES   (IMEM_BYTES)
    ) my_ins_mem (
        .clk     (clk),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata (32'd0),
        .i_addr  (pc[c_IAW-1:0]),
        .o_instr (w_instr)
    );

    assign w_op     = w_instr[31:26];
    assign w_rs     = w_instr[25:21];
    assign w_rt     = w_instr[20:16];
    assign w_rd     = w_instr[15:11];
    assign w_funct  = w_instr[5:0];
    assign w_imm    = w_instr[15:0];
    assign w_target = w_instr[25:0];

    assign w_imm_sext      = sext16(w_imm);
    assign w_pc_plus4      = pc + 32'd4;
    assign w_branch_target = {w_imm_sext[29:0], 2'b00};
    assign w_jump_target   = {w_pc_plus4[31:28], w_target, 2'b00};

    // ------------------------------------------------------------------
    // Register file (writes suppressed while reset is high)
    // ------------------------------------------------------------------
    reg_file u_reg_file (
        .clk      (clk),
        .rst      (reset),
        .i_we     (w_reg_we & ~reset),
        .i_waddr  (w_wr_idx),
        .i_wdata  (w_wr_data),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rs_data),
        .o_rdata2 (w_rt_data)
    );

    // ------------------------------------------------------------------
    // Decode: anything not matched falls through as a NOP
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_op     = ALU_ADD;
        w_alu_b      = w_rt_data;
        w_reg_we     = 1'b0;
        w_wr_idx     = w_rd;
        w_mem_we     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_link       = 1'b0;
        w_next_pc    = w_pc_plus4;

        case (w_op)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_FN_ADD: begin w_alu_op = ALU_ADD; w_reg_we = 1'b1; end
                    c_FN_SUB: begin w_alu_op = ALU_SUB; w_reg_we = 1'b1; end
                    c_FN_AND: begin w_alu_op = ALU_AND; w_reg_we = 1'b1; end
                    c_FN_OR:  begin w_alu_op = ALU_OR;  w_reg_we = 1'b1; end
                    c_FN_SLT: begin w_alu_op = ALU_SLT; w_reg_we = 1'b1; end
                    c_FN_JR:  w_next_pc = w_rs_data;
                    default:  ;
                endcase
            end
            c_OP_ADDI: begin
                w_alu_b  = w_imm_sext;
                w_reg_we = 1'b1;
                w_wr_idx = w_rt;
            end
            c_OP_LW: begin
                w_alu_b      = w_imm_sext;
                w_reg_we     = 1'b1;
                w_wr_idx     = w_rt;
                w_mem_to_reg = 1'b1;
            end
            c_OP_SW: begin
                w_alu_b  = w_imm_sext;
                w_mem_we = 1'b1;
            end
            c_OP_BEQ: begin
                if (w_rs_data == w_rt_data) w_next_pc = w_branch_target;
            end
            c_OP_BNE: begin
                if (w_rs_data != w_rt_data) w_next_pc = w_branch_target;
            end
            c_OP_J: begin
                w_next_pc = w_jump_target;
            end
            c_OP_JAL: begin
                w_next_pc = w_jump_target;
                w_reg_we  = 1'b1;
                w_wr_idx  = c_RA;
                w_link    = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU: wrapping arithmetic, signed set-less-than
    // ------------------------------------------------------------------
    always_comb begin
        case (w_alu_op)
            ALU_SUB: w_alu_result = w_rs_data - w_alu_b;
            ALU_AND: w_alu_result = w_rs_data & w_alu_b;
            ALU_OR:  w_alu_result = w_rs_data | w_alu_b;
            ALU_SLT: w_alu_result = {31'd0, $signed(w_rs_data) < $signed(w_alu_b)};
            default: w_alu_result = w_rs_data + w_alu_b;
        endcase
    end

    // ------------------------------------------------------------------
    // Data memory (address wraps to the low bits of the ALU result)
    // ------------------------------------------------------------------
    data_memory #(
        .BYTES   (DMEM_BYTES)
    ) data_mem (
        .clk     (clk),
        .i_we    (w_mem_we & ~reset),
        .i_addr  (w_alu_result[c_DAW-1:0]),
        .i_wdata (w_rt_data),
        .o_rdata (w_mem_rdata)
    );

    assign w_wr_data = w_link       ? w_pc_plus4  :
                       w_mem_to_reg ? w_mem_rdata :
                                      w_alu_result;

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= 32'd0;
        end else begin
            pc <= w_next_pc;
        end
    end

endmodule : mips_processor
`default_nettype wire

// File: tb/tb_mips_processor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_processor
//  Description : Directed self-checking bench for mips_processor. Preloads
//                programs into the private memories, steps the core one edge
//                at a time and compares pc, registers and data memory against
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_processor;

    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    logic [31:0] prev_word;
    logic [31:0] cur_word;
    int          cyc;

    mips_processor #(
        .IMEM_BYTES (256),
        .DMEM_BYTES (256)
    ) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // --------------------------------------------------------------
    // Helpers
    // --------------------------------------------------------------
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic put_imem(input int a, input logic [31:0] w);
        dut.my_ins_mem.memory[a]   = w[31:24];
        dut.my_ins_mem.memory[a+1] = w[23:16];
        dut.my_ins_mem.memory[a+2] = w[15:8];
        dut.my_ins_mem.memory[a+3] = w[7:0];
    endtask

    task automatic put_dmem(input int a, input logic [31:0] w);
        dut.data_mem.memory[a]   = w[31:24];
        dut.data_mem.memory[a+1] = w[23:16];
        dut.data_mem.memory[a+2] = w[15:8];
        dut.data_mem.memory[a+3] = w[7:0];
    endtask

    function automatic logic [31:0] dmem_word(input int a);
        return {dut.data_mem.memory[a],   dut.data_mem.memory[a+1],
                dut.data_mem.memory[a+2], dut.data_mem.memory[a+3]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // --------------------------------------------------------------
    // Directed sequence
    // --------------------------------------------------------------
    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dut.my_ins_mem.memory[i] = 8'h00;
            dut.data_mem.memory[i]   = 8'h00;
        end

        // Program A: jal to main, delay subroutine at 4, counting loop at 20
        put_imem(0,  32'h0C000005);                     // jal 5
        put_imem(4,  enc_i(6'h08, 5'd0, 5'd9, 16'd0));   // addi $9,$0,0
        put_imem(8,  enc_i(6'h08, 5'd9, 5'd9, 16'd1));   // addi $9,$9,1
        put_imem(12, enc_i(6'h05, 5'd9, 5'd4, 16'd2));   // bne $9,$4,2
        put_imem(16, enc_r(5'd31, 5'd0, 5'd0, 6'h08));   // jr $31
        put_imem(20, enc_i(6'h23, 5'd0, 5'd4, 16'd0));   // lw $4,0($0)
        put_imem(24, enc_i(6'h23, 5'd0, 5'd17, 16'd4));  // lw $17,4($0)
        put_imem(28, enc_i(6'h08, 5'd8, 5'd8, 16'd1));   // addi $8,$8,1
        put_imem(32, enc_i(6'h2B, 5'd0, 5'd8, 16'd8));   // sw $8,8($0)
        put_imem(36, enc_i(6'h04, 5'd8, 5'd17, 16'd17)); // beq $8,$17,17
        put_imem(40, enc_j(6'h03, 26'd1));               // jal 1
        put_imem(44, enc_j(6'h02, 26'd7));               // j 7
        put_imem(68, enc_j(6'h02, 26'd17));              // j 17 (halt)
        put_dmem(0, 32'd3);
        put_dmem(4, 32'd40);

        @(negedge clk);
        step();
        check("reset_pc_edge1", dut.pc, 32'd0);
        step();
        check("reset_pc_edge2", dut.pc, 32'd0);
        check("reset_ra", dut.u_reg_file.r_regs[31], 32'd0);
        reset = 1'b0;

        step(); check("jal5_pc", dut.pc, 32'd20);
                check("jal5_ra", dut.u_reg_file.r_regs[31], 32'd4);
        step(); check("lw_a0_pc", dut.pc, 32'd24);
                check("lw_a0", dut.u_reg_file.r_regs[4], 32'd3);
        step(); check("lw_s1", dut.u_reg_file.r_regs[17], 32'd40);
        step(); check("addi_t0", dut.u_reg_file.r_regs[8], 32'd1);
                check("addi_pc", dut.pc, 32'd32);
        step(); check("sw_word8", dmem_word(8), 32'd1);
                check("sw_byte11", {24'd0, dut.data_mem.memory[11]}, 32'd1);
        step(); check("beq_not_taken_pc", dut.pc, 32'd40);
        step(); check("jal1_pc", dut.pc, 32'd4);
                check("jal1_ra", dut.u_reg_file.r_regs[31], 32'd44);
        step(); check("sub_init_pc", dut.pc, 32'd8);
        step(); check("t1_inc1", dut.u_reg_file.r_regs[9], 32'd1);
        step(); check("bne_taken_pc", dut.pc, 32'd8);
        step(); step();
        step(); check("t1_inc3", dut.u_reg_file.r_regs[9], 32'd3);
                check("t1_inc3_pc", dut.pc, 32'd12);
        step(); check("bne_not_taken_pc", dut.pc, 32'd16);
        step(); check("jr_pc", dut.pc, 32'd44);
        step(); check("j7_pc", dut.pc, 32'd28);

        // Run the rest of the counting loop; each store must be last+1
        prev_word = 32'd1;
        cyc = 0;
        while (dut.pc != 32'd68 && cyc < 2000) begin
            step();
            cyc++;
            cur_word = dmem_word(8);
            if (cur_word != prev_word) begin
                check("dmem8_increment", cur_word, prev_word + 32'd1);
                prev_word = cur_word;
            end
        end
        check("reach_pc68", dut.pc, 32'd68);
        check("final_word8", dmem_word(8), 32'd40);
        check("final_t0", dut.u_reg_file.r_regs[8], 32'd40);
        step(); step();
        check("halt_pc68", dut.pc, 32'd68);

        // Mid-program reset: registers cleared, memory kept
        reset = 1'b1;
        step();
        check("midreset_pc", dut.pc, 32'd0);
        check("midreset_ra", dut.u_reg_file.r_regs[31], 32'd0);
        check("midreset_t0", dut.u_reg_file.r_regs[8], 32'd0);
        check("midreset_dmem_kept", dmem_word(8), 32'd40);

        // Program B: $0 write, unknown op/funct, ALU ops, absolute beq
        put_imem(0,   enc_i(6'h08, 5'd0, 5'd0, 16'd5));        // addi $0,$0,5
        put_imem(4,   enc_i(6'h3F, 5'd0, 5'd7, 16'd5));        // unknown opcode
        put_imem(8,   enc_r(5'd1, 5'd2, 5'd5, 6'h3F));         // unknown funct
        put_imem(12,  enc_i(6'h08, 5'd0, 5'd10, 16'hFFFB));    // addi $10,$0,-5
        put_imem(16,  enc_i(6'h08, 5'd0, 5'd11, 16'd3));       // addi $11,$0,3
        put_imem(20,  enc_r(5'd10, 5'd11, 5'd12, 6'h2A));      // slt $12,$10,$11
        put_imem(24,  enc_r(5'd11, 5'd10, 5'd13, 6'h22));      // sub $13,$11,$10
        put_imem(28,  enc_r(5'd10, 5'd11, 5'd14, 6'h20));      // add $14,$10,$11
        put_imem(32,  enc_r(5'd10, 5'd11, 5'd15, 6'h24));      // and $15,$10,$11
        put_imem(36,  enc_r(5'd10, 5'd11, 5'd16, 6'h25));      // or  $16,$10,$11
        put_imem(40,  enc_r(5'd11, 5'd10, 5'd18, 6'h2A));      // slt $18,$11,$10
        put_imem(44,  enc_i(6'h04, 5'd0, 5'd0, 16'd32));       // beq $0,$0,32
        put_imem(128, enc_j(6'h02, 26'd32));                   // j 32 (halt)
        step();
        check("reset_hold_pc", dut.pc, 32'd0);
        reset = 1'b0;

        step(); check("r0_write_pc", dut.pc, 32'd4);
                check("r0_stays_zero", dut.u_reg_file.r_regs[0], 32'd0);
        step(); check("unknown_op_pc", dut.pc, 32'd8);
                check("unknown_op_no_reg", dut.u_reg_file.r_regs[7], 32'd0);
                check("unknown_op_no_mem", dmem_word(8), 32'd40);
        step(); check("unknown_fn_pc", dut.pc, 32'd12);
                check("unknown_fn_no_reg", dut.u_reg_file.r_regs[5], 32'd0);
        step(); check("addi_neg", dut.u_reg_file.r_regs[10], 32'hFFFF_FFFB);
        step(); check("addi_pos", dut.u_reg_file.r_regs[11], 32'd3);
        step(); check("slt_true", dut.u_reg_file.r_regs[12], 32'd1);
        step(); check("sub", dut.u_reg_file.r_regs[13], 32'd8);
        step(); check("add_wrap", dut.u_reg_file.r_regs[14], 32'hFFFF_FFFE);
        step(); check("and", dut.u_reg_file.r_regs[15], 32'd3);
        step(); check("or", dut.u_reg_file.r_regs[16], 32'hFFFF_FFFB);
        step(); check("slt_signed_false", dut.u_reg_file.r_regs[18], 32'd0);
                check("slt_pc", dut.pc, 32'd44);
        step(); check("beq_taken_pc", dut.pc, 32'd128);
        step(); check("j_halt_pc", dut.pc, 32'd128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mips_processor
`default_nettype wire
